// File: rtl/vpu_pkg.sv
// Shared VPU SRAM constants, the read latency tag carried down the latency pipe,
// and the burst FSM state type used by the SRAM read responder.
package vpu_pkg;

  localparam int unsigned SRAM_BANK_CNT       = 8;
  localparam int unsigned SRAM_BANK_CNT_LG2   = 3;
  localparam int unsigned SRAM_BANK_DEPTH_LG2 = 10;
  localparam int unsigned SRAM_DATA_WIDTH     = 512;
  localparam int unsigned SRAM_RD_LAT         = 2;

  typedef struct packed {
    logic                         valid;
    logic [SRAM_BANK_CNT_LG2-1:0] rid;
  } vpu_rd_tag_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } vpu_rd_state_t;

endpackage

// File: rtl/vpu_rd_lat_pipe.sv
// Shift register of read tags, RD_LAT+1 stages deep; the last stage lines up
// with the cycle in which the selected bank presents its read data.
module vpu_rd_lat_pipe
  import vpu_pkg::*;
#(
  parameter int unsigned RD_LAT = SRAM_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  vpu_rd_tag_t in_tag,
  output vpu_rd_tag_t out_tag,
  output logic        busy
);

  vpu_rd_tag_t stages [RD_LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_tag;
      for (int unsigned i = 1; i <= RD_LAT; i++) stages[i] <= stages[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i <= RD_LAT; i++) busy = busy | stages[i].valid;
  end

  assign out_tag = stages[RD_LAT];

endmodule

// File: rtl/vpu_sram_rd_responder.sv
// SRAM-side responder for one VPU source read port: 2-cycle req/ack handshake,
// one-hot bank reads, fixed-latency return. Optional VPU_SRAM_RSP_STAT_EN adds beat/burst counters.
module vpu_sram_rd_responder
  import vpu_pkg::*;
#(
  parameter int unsigned BANK_CNT   = SRAM_BANK_CNT,
  parameter int unsigned DEPTH_LG2  = SRAM_BANK_DEPTH_LG2,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned RD_LAT     = SRAM_RD_LAT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  output logic                           ack,
  input  logic [$clog2(BANK_CNT)-1:0]    rid,
  input  logic [DEPTH_LG2-1:0]           addr,
  input  logic                           reb,
  input  logic                           rlast,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  output logic [BANK_CNT-1:0]            bank_csb,
  output logic [DEPTH_LG2-1:0]           bank_addr,
  input  logic [BANK_CNT*DATA_WIDTH-1:0] bank_rdata,
  output logic                           busy,
  output logic                           err
`ifdef VPU_SRAM_RSP_STAT_EN
  ,
  output logic [31:0]                    stat_beats,
  output logic [15:0]                    stat_bursts
`endif
);

  localparam int unsigned RID_W = $clog2(BANK_CNT);

  vpu_rd_state_t     state;
  logic [RID_W-1:0]  burst_rid;
  logic              accept;
  vpu_rd_tag_t       tag_in;
  vpu_rd_tag_t       tag_out;
  logic              pipe_busy;
  logic [RID_W-1:0]  tail_rid;
  logic [DATA_WIDTH-1:0] sel_data;

  assign accept       = req && ack;
  assign tag_in.valid = accept && !reb;
  assign tag_in.rid   = SRAM_BANK_CNT_LG2'(rid);
  assign tail_rid     = RID_W'(tag_out.rid);

  vpu_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (tag_in),
    .out_tag (tag_out),
    .busy    (pipe_busy)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < BANK_CNT; i++) begin
      if (tail_rid == RID_W'(i)) sel_data = bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ack toggles off after every ack cycle, which caps throughput at one beat per two cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      bank_csb  <= '1;
      bank_addr <= '0;
      err       <= 1'b0;
      state     <= ST_IDLE;
      burst_rid <= '0;
`ifdef VPU_SRAM_RSP_STAT_EN
      stat_beats  <= '0;
      stat_bursts <= '0;
`endif
    end else begin
      ack      <= req && !ack;
      bank_csb <= '1;
      rvalid   <= tag_out.valid;
      if (tag_out.valid) rdata <= sel_data;
      if (accept) begin
        if (!reb) begin
          bank_csb[rid] <= 1'b0;
          bank_addr     <= addr;
        end else begin
          err <= 1'b1;
        end
        case (state)
          ST_IDLE: begin
            if (!rlast) begin
              state     <= ST_BURST;
              burst_rid <= rid;
            end
          end
          ST_BURST: begin
            if (rid != burst_rid) err <= 1'b1;
            if (rlast) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
`ifdef VPU_SRAM_RSP_STAT_EN
        if (!reb) stat_beats <= stat_beats + 32'd1;
        if (rlast) stat_bursts <= stat_bursts + 16'd1;
`endif
      end
    end
  end

  assign busy = (state == ST_BURST) || pipe_busy;

endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// Randomised bench for vpu_sram_rd_responder: behavioural SRAM bank model plus a
// cycle-keyed reference of expected chip-selects, returns, busy and err.
module tb_vpu_sram_rd_responder;
  import vpu_pkg::*;

  localparam int NB = SRAM_BANK_CNT;
  localparam int DW = SRAM_DATA_WIDTH;
  localparam int AW = SRAM_BANK_DEPTH_LG2;
  localparam int RW = SRAM_BANK_CNT_LG2;
  localparam int RL = SRAM_RD_LAT;

  logic              clk;
  logic              rst;
  logic              req;
  logic              ack;
  logic [RW-1:0]     rid;
  logic [AW-1:0]     addr;
  logic              reb;
  logic              rlast;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [NB-1:0]     bank_csb;
  logic [AW-1:0]     bank_addr;
  logic [NB*DW-1:0]  bank_rdata;
  logic              busy;
  logic              err;
`ifdef VPU_SRAM_RSP_STAT_EN
  logic [31:0]       stat_beats;
  logic [15:0]       stat_bursts;
`endif

  vpu_sram_rd_responder #(
    .BANK_CNT   (NB),
    .DEPTH_LG2  (AW),
    .DATA_WIDTH (DW),
    .RD_LAT     (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .rid        (rid),
    .addr       (addr),
    .reb        (reb),
    .rlast      (rlast),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .bank_csb   (bank_csb),
    .bank_addr  (bank_addr),
    .bank_rdata (bank_rdata),
    .busy       (busy),
    .err        (err)
`ifdef VPU_SRAM_RSP_STAT_EN
    ,
    .stat_beats  (stat_beats),
    .stat_bursts (stat_bursts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  bit a5_mode = 1'b0;

  function automatic logic [DW-1:0] mem_word(input int b, input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++)
      w[k*32 +: 32] = (32'(b) * 32'h0100_0193) ^ (32'(a) * 32'h9E37_79B1) ^ (32'(k) * 32'h85EB_CA6B) ^ 32'h5A5A_0000;
    if (a5_mode && b == 3) w = {(DW/8){8'hA5}};
    return w;
  endfunction

  // SRAM banks: a read selected in cycle C presents data during cycle C+RL only
  int            pend_cyc  [NB][16];
  logic [AW-1:0] pend_addr [NB][16];

  initial begin
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < 16; s++) pend_cyc[b][s] = -1;
    forever begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        if (bank_csb[b] === 1'b0) begin
          pend_cyc[b][(cyc + RL) % 16]  = cyc + RL;
          pend_addr[b][(cyc + RL) % 16] = bank_addr;
        end
      end
    end
  end

  initial begin
    bank_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
        if (pend_cyc[b][cyc % 16] == cyc)
          bank_rdata[b*DW +: DW] = mem_word(b, int'(pend_addr[b][cyc % 16]));
        else
          for (int k = 0; k < DW/32; k++) bank_rdata[b*DW + k*32 +: 32] = $urandom;
      end
    end
  end

  // Reference expectations keyed by the cycle in which they must be observed
  logic [DW-1:0] exp_rd    [int];
  logic [RW-1:0] csb_rid   [int];
  logic [AW-1:0] csb_addr  [int];
  bit            busy_sched[int];
  bit            burst_sched[int];
  int            err_at      = -1;
  bit            m_burst_mon = 1'b0;
  bit            mon_en      = 1'b0;
  logic [DW-1:0] last_rd     = '0;
  bit            m_in_burst  = 1'b0;
  logic [RW-1:0] m_brid      = '0;
  int            m_beats     = 0;
  int            m_bursts    = 0;

  initial begin
    logic [NB-1:0] e_csb;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (burst_sched.exists(cyc)) m_burst_mon = burst_sched[cyc];
        e_csb = '1;
        if (csb_rid.exists(cyc)) begin
          e_csb[csb_rid[cyc]] = 1'b0;
          check_val("bank_addr", bank_addr, csb_addr[cyc]);
        end
        check_val("bank_csb", bank_csb, e_csb);
        check_val("rvalid", rvalid, exp_rd.exists(cyc));
        if (exp_rd.exists(cyc)) last_rd = exp_rd[cyc];
        check_val("rdata", rdata, last_rd);
        check_val("busy", busy, m_burst_mon || busy_sched.exists(cyc));
        check_val("err", err, (err_at >= 0) && (cyc >= err_at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic note_err();
    if (err_at < 0) err_at = cyc + 1;
  endtask

  task automatic do_beat(input logic [RW-1:0] r, input logic [AW-1:0] a,
                         input bit e, input bit l, input bit cont);
    req = 1'b1; rid = r; addr = a; reb = e; rlast = l;
    @(negedge clk);
    check_val("ack_lo", ack, 1'b0);
    tick();
    @(negedge clk);
    check_val("ack_hi", ack, 1'b1);
    if (!e) begin
      csb_rid[cyc + 1]       = r;
      csb_addr[cyc + 1]      = a;
      exp_rd[cyc + RL + 2]   = mem_word(int'(r), int'(a));
      for (int k = 1; k <= RL + 1; k++) busy_sched[cyc + k] = 1'b1;
      m_beats++;
    end else begin
      note_err();
    end
    if (l) m_bursts++;
    if (!m_in_burst) begin
      if (!l) begin
        m_in_burst = 1'b1;
        m_brid     = r;
        burst_sched[cyc + 1] = 1'b1;
      end
    end else begin
      if (r != m_brid) note_err();
      if (l) begin
        m_in_burst = 1'b0;
        burst_sched[cyc + 1] = 1'b0;
      end
    end
    tick();
    if (!cont) begin
      req = 1'b0; rid = RW'($urandom); addr = AW'($urandom); reb = 1'($urandom); rlast = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; mon_en = 1'b0;
    tick();
    rst = 1'b0;
    exp_rd.delete(); csb_rid.delete(); csb_addr.delete();
    busy_sched.delete(); burst_sched.delete();
    err_at = -1; m_in_burst = 1'b0; m_burst_mon = 1'b0;
    last_rd = '0; m_beats = 0; m_bursts = 0;
    @(negedge clk);
    check_val("rst_ack", ack, 1'b0);
    check_val("rst_rvalid", rvalid, 1'b0);
    check_val("rst_rdata", rdata, '0);
    check_val("rst_csb", bank_csb, {NB{1'b1}});
    check_val("rst_bank_addr", bank_addr, '0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_err", err, 1'b0);
`ifdef VPU_SRAM_RSP_STAT_EN
    check_val("rst_stat_beats", stat_beats, '0);
    check_val("rst_stat_bursts", stat_bursts, '0);
`endif
    mon_en = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0; rid = '0; addr = '0; reb = 1'b0; rlast = 1'b0;
    tick();
    tick();
    do_reset();

    // Single read from bank 3 returning the A5 pattern
    a5_mode = 1'b1;
    do_beat(3'd3, AW'('h10), 1'b0, 1'b1, 1'b0);
    idle(RL + 4);
    a5_mode = 1'b0;

    // Four-beat burst on bank 1, back-to-back requests
    for (int i = 0; i < 4; i++) do_beat(3'd1, AW'(i), 1'b0, (i == 3), (i != 3));
    idle(RL + 4);

    // reb=1 beat: acked, no access, err sticky
    do_beat(3'd6, AW'('h55), 1'b1, 1'b1, 1'b0);
    idle(RL + 6);
    do_reset();

    // Burst rid mismatch: second beat still served from its own bank
    do_beat(3'd2, AW'('h20), 1'b0, 1'b0, 1'b1);
    do_beat(3'd5, AW'('h21), 1'b0, 1'b1, 1'b0);
    idle(RL + 4);
    do_reset();

    // Reset one cycle after the chip-select cycle kills the in-flight read
    do_beat(3'd4, AW'('h33), 1'b0, 1'b1, 1'b0);
    tick();
    do_reset();
    idle(RL + 4);

`ifdef VPU_SRAM_RSP_STAT_EN
    for (int i = 0; i < 3; i++) do_beat(3'd4, AW'(i + 8), 1'b0, (i == 2), (i != 2));
    do_beat(3'd7, AW'('h3F), 1'b0, 1'b1, 1'b0);
    idle(RL + 4);
    check_val("stat_beats", stat_beats, 32'(m_beats));
    check_val("stat_bursts", stat_bursts, 16'(m_bursts));
    do_reset();
`endif

    // Randomised bursts with occasional reb=1 beats and rid mismatches
    for (int bu = 0; bu < 40; bu++) begin
      int            len;
      logic [RW-1:0] brid;
      len  = int'($urandom_range(1, 4));
      brid = RW'($urandom);
      for (int i = 0; i < len; i++) begin
        logic [RW-1:0] r;
        bit            e;
        bit            c;
        r = ($urandom_range(0, 9) == 0) ? RW'($urandom) : brid;
        e = ($urandom_range(0, 19) == 0);
        c = (bu == 39 && i == len - 1) ? 1'b0 : 1'($urandom);
        do_beat(r, AW'($urandom), e, (i == len - 1), c);
        if (!c) idle(int'($urandom_range(0, 3)));
      end
    end
    idle(RL + 6);
    check_val("final_busy", busy, 1'b0);
`ifdef VPU_SRAM_RSP_STAT_EN
    check_val("rand_stat_beats", stat_beats, 32'(m_beats));
    check_val("rand_stat_bursts", stat_bursts, 16'(m_bursts));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
